// File: rtl/hockey_pkg.sv
// Shared constants, bounds helpers and state type for the air-hockey paddle logic.
package hockey_pkg;

  localparam int DEF_WIDTH  = 96;
  localparam int DEF_HEIGHT = 64;
  localparam int DEF_PAD_H  = 20;

  localparam logic [15:0] COL_RED  = 16'hF800;
  localparam logic [15:0] COL_BLUE = 16'h001F;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } btnState_t;

  function automatic int padYMin(input int padH);
    return padH / 2;
  endfunction

  function automatic int padYMax(input int height, input int padH);
    return height - padH / 2;
  endfunction

  function automatic int clampY(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/paddle_btn_repeat.sv
// Hold-to-repeat button FSM: emits one-tick move pulses for the user paddle.
module paddle_btn_repeat
  import hockey_pkg::*;
#(
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_enUser,
  input  logic i_btnU,
  input  logic i_btnD,
  output logic o_moveUp,
  output logic o_moveDown
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  btnState_t        r_state, w_nextState;
  logic [CNT_W-1:0] r_cnt, w_nextCnt;
  logic             r_dir, w_nextDir;
  logic             w_pressed, w_dir, w_move;

  assign w_pressed = i_enUser & (i_btnU ^ i_btnD);
  assign w_dir     = i_btnD;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_dir   <= w_nextDir;
    end
  end

  // A direction change while held counts as a fresh press.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextDir   = r_dir;
    w_move      = 1'b0;
    if (i_tick) begin
      if (!w_pressed) begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end else if (r_state == IDLE || w_dir != r_dir) begin
        w_move      = 1'b1;
        w_nextState = DELAY;
        w_nextCnt   = '0;
        w_nextDir   = w_dir;
      end else if (r_state == DELAY) begin
        if (r_cnt == CNT_W'(REPEAT_DELAY - 1)) begin
          w_move      = 1'b1;
          w_nextState = REPEAT;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end else begin
        if (r_cnt == CNT_W'(REPEAT_PERIOD - 1)) begin
          w_move    = 1'b1;
          w_nextCnt = '0;
        end else begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_moveUp   = w_move & ~w_dir;
  assign o_moveDown = w_move & w_dir;

endmodule

// File: rtl/hockey_paddle_ctrl.sv
// Two-paddle controller: user paddle via buttons, audio/puck-tracking opponent
// paddle with slew limit, plus per-pixel hit and colour outputs.
module hockey_paddle_ctrl
  import hockey_pkg::*;
#(
  parameter int          WIDTH         = DEF_WIDTH,
  parameter int          HEIGHT        = DEF_HEIGHT,
  parameter int          PAD_H         = DEF_PAD_H,
  parameter int          PAD_W         = 3,
  parameter int          BORDER        = 3,
  parameter int          STEP          = 3,
  parameter int          LEVEL_BITS    = 4,
  parameter int          REPEAT_DELAY  = 8,
  parameter int          REPEAT_PERIOD = 2,
  parameter int          COORD_W       = 7,
  parameter logic [15:0] USER_COL      = COL_RED,
  parameter logic [15:0] AUDIO_COL     = COL_BLUE
) (
  input  logic                  clkPaddle,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  enUser,
  input  logic                  btnU,
  input  logic                  btnD,
  input  logic                  mode,
  input  logic [LEVEL_BITS-1:0] level,
  input  logic [COORD_W-1:0]    puckY,
  input  logic [COORD_W-1:0]    x,
  input  logic [COORD_W-1:0]    y,
  output logic [COORD_W-1:0]    userPaddleX,
  output logic [COORD_W-1:0]    userPaddleY,
  output logic [COORD_W-1:0]    audioPaddleX,
  output logic [COORD_W-1:0]    audioPaddleY,
  output logic                  userPaddleAppear,
  output logic                  audioPaddleAppear,
  output logic [15:0]           userPaddle_col,
  output logic [15:0]           audioPaddle_col,
  output logic                  audioAtTarget
);

  localparam int YMIN = padYMin(PAD_H);
  localparam int YMAX = padYMax(HEIGHT, PAD_H);
  localparam logic [COORD_W:0] HALF_W = (COORD_W + 1)'(PAD_W / 2);
  localparam logic [COORD_W:0] HALF_H = (COORD_W + 1)'(PAD_H / 2);

  logic [COORD_W-1:0] r_userY, r_audioY;
  logic               w_moveUp, w_moveDown;
  int                 w_target, w_diff, w_audioNext, w_userNext;

  paddle_btn_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_btnRepeat (
    .i_clk     (clkPaddle),
    .i_reset   (reset),
    .i_tick    (tick),
    .i_enUser  (enUser),
    .i_btnU    (btnU),
    .i_btnD    (btnD),
    .o_moveUp  (w_moveUp),
    .o_moveDown(w_moveDown)
  );

  // Target and slew step; within one STEP the paddle snaps onto the target.
  always_comb begin
    w_target    = YMIN;
    w_diff      = 0;
    w_audioNext = int'(r_audioY);
    w_userNext  = int'(r_userY);
    if (mode) w_target = clampY(int'(puckY), YMIN, YMAX);
    else      w_target = clampY(YMAX - STEP * int'(level), YMIN, YMAX);
    w_diff = int'(r_audioY) - w_target;
    if (w_diff <= STEP && w_diff >= -STEP) w_audioNext = w_target;
    else if (w_diff > 0)                   w_audioNext = int'(r_audioY) - STEP;
    else                                   w_audioNext = int'(r_audioY) + STEP;
    if (w_moveUp)        w_userNext = clampY(int'(r_userY) - STEP, YMIN, YMAX);
    else if (w_moveDown) w_userNext = clampY(int'(r_userY) + STEP, YMIN, YMAX);
  end

  always_ff @(posedge clkPaddle) begin
    if (reset) begin
      r_userY  <= COORD_W'(HEIGHT / 2);
      r_audioY <= COORD_W'(HEIGHT / 2);
    end else if (tick) begin
      r_userY  <= COORD_W'(w_userNext);
      r_audioY <= COORD_W'(w_audioNext);
    end
  end

  assign userPaddleX     = COORD_W'(BORDER);
  assign audioPaddleX    = COORD_W'(WIDTH - BORDER);
  assign userPaddleY     = r_userY;
  assign audioPaddleY    = r_audioY;
  assign userPaddle_col  = USER_COL;
  assign audioPaddle_col = AUDIO_COL;
  assign audioAtTarget   = (int'(r_audioY) == w_target);

  // Bounds are compared with the half-size added to the pixel side so nothing underflows.
  logic [COORD_W:0] w_x, w_y, w_uX, w_uY, w_aX, w_aY;
  assign w_x  = {1'b0, x};
  assign w_y  = {1'b0, y};
  assign w_uX = {1'b0, userPaddleX};
  assign w_uY = {1'b0, r_userY};
  assign w_aX = {1'b0, audioPaddleX};
  assign w_aY = {1'b0, r_audioY};

  assign userPaddleAppear = (w_x + HALF_W >= w_uX) && (w_x <= w_uX + HALF_W) &&
                            (w_y + HALF_H >= w_uY) && (w_y < w_uY + HALF_H);
  assign audioPaddleAppear = (w_x + HALF_W >= w_aX) && (w_x <= w_aX + HALF_W) &&
                             (w_y + HALF_H >= w_aY) && (w_y < w_aY + HALF_H);

endmodule

// File: tb/tb_hockey_paddle_ctrl.sv
// Directed self-checking bench for hockey_paddle_ctrl with default parameters.
module tb_hockey_paddle_ctrl;

  logic       clkPaddle = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       enUser = 1'b0;
  logic       btnU = 1'b0;
  logic       btnD = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] level = 4'd0;
  logic [6:0] puckY = 7'd0;
  logic [6:0] x = 7'd0;
  logic [6:0] y = 7'd0;
  logic [6:0] userPaddleX, userPaddleY, audioPaddleX, audioPaddleY;
  logic       userPaddleAppear, audioPaddleAppear, audioAtTarget;
  logic [15:0] userPaddle_col, audioPaddle_col;

  int checkCount = 0;
  int passCount  = 0;

  hockey_paddle_ctrl dut (
    .clkPaddle        (clkPaddle),
    .reset            (reset),
    .tick             (tick),
    .enUser           (enUser),
    .btnU             (btnU),
    .btnD             (btnD),
    .mode             (mode),
    .level            (level),
    .puckY            (puckY),
    .x                (x),
    .y                (y),
    .userPaddleX      (userPaddleX),
    .userPaddleY      (userPaddleY),
    .audioPaddleX     (audioPaddleX),
    .audioPaddleY     (audioPaddleY),
    .userPaddleAppear (userPaddleAppear),
    .audioPaddleAppear(audioPaddleAppear),
    .userPaddle_col   (userPaddle_col),
    .audioPaddle_col  (audioPaddle_col),
    .audioAtTarget    (audioAtTarget)
  );

  always #5 clkPaddle = ~clkPaddle;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // Runs n clock cycles with tick high (or low when withTick is 0).
  task automatic applyStimulus(input int n, input bit withTick = 1'b1);
    tick = withTick;
    repeat (n) @(posedge clkPaddle);
    #1;
    tick = 1'b0;
  endtask

  task automatic applyReset();
    tick  = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clkPaddle);
    #1;
    reset = 1'b0;
  endtask

  task automatic probePixel(input int px, input int py);
    x = 7'(px);
    y = 7'(py);
    #1;
  endtask

  initial begin
    applyReset();
    applyStimulus(20, 1'b0);
    checkOutput("rstUserY", userPaddleY, 32);
    checkOutput("rstAudioY", audioPaddleY, 32);
    checkOutput("rstAtTarget", audioAtTarget, 0);
    checkOutput("userX", userPaddleX, 3);
    checkOutput("audioX", audioPaddleX, 93);
    checkOutput("userCol", userPaddle_col, 16'hF800);
    checkOutput("audioCol", audioPaddle_col, 16'h001F);

    // Hold-to-repeat upward with saturation at the top bound.
    enUser = 1'b1;
    btnU   = 1'b1;
    applyStimulus(1);  checkOutput("upTick1", userPaddleY, 29);
    applyStimulus(7);  checkOutput("upTick8", userPaddleY, 29);
    applyStimulus(1);  checkOutput("upTick9", userPaddleY, 26);
    applyStimulus(1);  checkOutput("upTick10", userPaddleY, 26);
    applyStimulus(1);  checkOutput("upTick11", userPaddleY, 23);
    applyStimulus(8);  checkOutput("upTick19", userPaddleY, 11);
    applyStimulus(1);  checkOutput("upTick20", userPaddleY, 11);
    applyStimulus(1);  checkOutput("upTick21", userPaddleY, 10);
    applyStimulus(4);  checkOutput("upHoldMin", userPaddleY, 10);
    applyStimulus(5, 1'b0); checkOutput("noTickHold", userPaddleY, 10);

    // Reset mid-repeat, then the held button acts as a fresh press.
    applyReset();
    checkOutput("rstMidRepeat", userPaddleY, 32);
    applyStimulus(1);  checkOutput("freshPress", userPaddleY, 29);

    // Direction change moves immediately.
    btnU = 1'b0;
    applyReset();
    btnU = 1'b1;
    applyStimulus(1);  checkOutput("dirTick1", userPaddleY, 29);
    applyStimulus(2);  checkOutput("dirTick3", userPaddleY, 29);
    btnU = 1'b0;
    btnD = 1'b1;
    applyStimulus(1);  checkOutput("dirDown", userPaddleY, 32);
    btnU = 1'b1;
    applyStimulus(3);  checkOutput("bothPressed", userPaddleY, 32);
    btnU   = 1'b0;
    enUser = 1'b0;
    applyStimulus(3);  checkOutput("disabled", userPaddleY, 32);
    btnD = 1'b0;

    // Audio paddle, level target.
    applyReset();
    mode  = 1'b0;
    level = 4'd0;
    applyStimulus(7);  checkOutput("audUp7", audioPaddleY, 53);
    checkOutput("audNotAt", audioAtTarget, 0);
    applyStimulus(1);  checkOutput("audUp8", audioPaddleY, 54);
    checkOutput("audAtTop", audioAtTarget, 1);
    level = 4'd15;
    #1;
    checkOutput("audRetarget", audioAtTarget, 0);
    applyStimulus(14); checkOutput("audDown14", audioPaddleY, 12);
    applyStimulus(1);  checkOutput("audDown15", audioPaddleY, 10);
    checkOutput("audAtBottom", audioAtTarget, 1);

    // Puck tracking with clamped target, reset during travel.
    mode  = 1'b1;
    puckY = 7'd70;
    applyStimulus(3);  checkOutput("puckUp3", audioPaddleY, 19);
    reset = 1'b1;
    tick  = 1'b1;
    @(posedge clkPaddle);
    #1;
    reset = 1'b0;
    tick  = 1'b0;
    checkOutput("rstOverTick", audioPaddleY, 32);
    puckY = 7'd0;
    applyStimulus(7);  checkOutput("puckDown7", audioPaddleY, 11);
    applyStimulus(1);  checkOutput("puckDown8", audioPaddleY, 10);
    checkOutput("puckAt", audioAtTarget, 1);

    // Hit test against the freshly reset paddles (both Y = 32).
    applyReset();
    probePixel(2, 22);  checkOutput("hit2_22", userPaddleAppear, 1);
    probePixel(4, 41);  checkOutput("hit4_41", userPaddleAppear, 1);
    probePixel(5, 22);  checkOutput("miss5_22", userPaddleAppear, 0);
    probePixel(3, 21);  checkOutput("miss3_21", userPaddleAppear, 0);
    probePixel(3, 42);  checkOutput("miss3_42", userPaddleAppear, 0);
    probePixel(92, 22); checkOutput("audHit92", audioPaddleAppear, 1);
    probePixel(95, 30); checkOutput("audMiss95", audioPaddleAppear, 0);
    probePixel(3, 30);  checkOutput("audMissUserCol", audioPaddleAppear, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
